// File: rtl/completion_arbiter_pkg.sv
// Shared types and helpers for completion arbitration and checkpoint recall.
package completion_arbiter_pkg;

    localparam int AL_SIZE_DEFAULT    = 32;
    localparam int AL_IW              = $clog2(AL_SIZE_DEFAULT);
    localparam int NUM_COMPLETION_SRC = 4;
    // Widest active-list index the window helper handles.
    localparam int AL_MAX_IW          = 16;

    typedef struct packed {
        logic             valid;
        logic [AL_IW-1:0] idx;
    } completion_t;

    // True iff x lies in the recalled range (lo, hi], with arithmetic
    // wrapping modulo 2**iw. lo itself is never inside; lo == hi is empty.
    function automatic logic al_in_window(
        input logic [AL_MAX_IW-1:0] x,
        input logic [AL_MAX_IW-1:0] lo,
        input logic [AL_MAX_IW-1:0] hi,
        input int unsigned          iw = AL_IW
    );
        logic [AL_MAX_IW-1:0] mask;
        logic [AL_MAX_IW-1:0] off;
        logic [AL_MAX_IW-1:0] span;
        mask = AL_MAX_IW'((32'd1 << iw) - 32'd1);
        off  = (x - lo) & mask;
        span = (hi - lo) & mask;
        return (off != '0) && (off <= span);
    endfunction

endpackage

// File: rtl/completion_fifo2.sv
// Two-entry completion buffer with push, pop and recall squash/compaction.
module completion_fifo2
    import completion_arbiter_pkg::*;
#(
    parameter int IW = AL_IW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [IW-1:0] push_idx,
    input  logic          pop,
    input  logic          squash,
    input  logic [IW-1:0] new_front,
    input  logic [IW-1:0] al_front,
    output logic [IW-1:0] head,
    output logic [1:0]    count,
    output logic          ready
);

    logic [IW-1:0] mem_reg [2];
    logic          hd_reg;
    logic          tl_reg;
    logic [1:0]    count_reg;

    logic          keep0;
    logic          keep1;
    logic          keep_in;
    logic [IW-1:0] comp0_next;
    logic [IW-1:0] comp1_next;
    logic [1:0]    count_next;

    // Decide which buffered entries and which incoming index survive a recall.
    always_comb begin
        keep0   = (count_reg != 2'd0) &&
                  !al_in_window(AL_MAX_IW'(mem_reg[hd_reg]), AL_MAX_IW'(new_front),
                                AL_MAX_IW'(al_front), IW);
        keep1   = (count_reg == 2'd2) &&
                  !al_in_window(AL_MAX_IW'(mem_reg[~hd_reg]), AL_MAX_IW'(new_front),
                                AL_MAX_IW'(al_front), IW);
        keep_in = push &&
                  !al_in_window(AL_MAX_IW'(push_idx), AL_MAX_IW'(new_front),
                                AL_MAX_IW'(al_front), IW);
    end

    // Pack survivors in age order (head, second, incoming) from slot 0.
    // Push is only possible with at most one entry held, so two slots suffice.
    always_comb begin
        comp0_next = '0;
        comp1_next = '0;
        count_next = 2'd0;
        if (keep0) begin
            comp0_next = mem_reg[hd_reg];
            count_next = 2'd1;
        end
        if (keep1) begin
            if (count_next == 2'd0) comp0_next = mem_reg[~hd_reg];
            else                    comp1_next = mem_reg[~hd_reg];
            count_next = count_next + 2'd1;
        end
        if (keep_in) begin
            if (count_next == 2'd0) comp0_next = push_idx;
            else                    comp1_next = push_idx;
            count_next = count_next + 2'd1;
        end
    end

    // FIFO state: recall rewrites storage compacted, otherwise normal push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 2'd0;
            hd_reg    <= 1'b0;
            tl_reg    <= 1'b0;
        end else if (squash) begin
            mem_reg[0] <= comp0_next;
            mem_reg[1] <= comp1_next;
            hd_reg     <= 1'b0;
            tl_reg     <= count_next[0];
            count_reg  <= count_next;
        end else begin
            if (push) begin
                mem_reg[tl_reg] <= push_idx;
                tl_reg          <= ~tl_reg;
            end
            if (pop) begin
                hd_reg <= ~hd_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem_reg[hd_reg];
    assign count = count_reg;
    assign ready = !reset && (count_reg != 2'd2);

endmodule

// File: rtl/completion_arbiter.sv
// Round-robin arbitration of per-source completion buffers onto the
// active list completion ports, with squash on checkpoint recall.
module completion_arbiter
    import completion_arbiter_pkg::*;
#(
    parameter  int AL_SIZE   = AL_SIZE_DEFAULT,
    parameter  int NUM_SRC   = NUM_COMPLETION_SRC,
    parameter  int NUM_PORTS = 2,
    localparam int IW        = $clog2(AL_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          src_valid [NUM_SRC],
    input  logic [IW-1:0] src_idx [NUM_SRC],
    output logic          src_ready [NUM_SRC],
    input  logic          recall_checkpoint,
    input  logic [IW-1:0] new_front,
    input  logic [IW-1:0] al_front,
    output logic          completed_valid [NUM_PORTS],
    output logic [IW-1:0] completed_idx [NUM_PORTS]
);

    localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [IW-1:0]      fifo_head [NUM_SRC];
    logic [1:0]         fifo_count [NUM_SRC];
    logic [NUM_SRC-1:0] fifo_ready;
    logic [NUM_SRC-1:0] push_vec;
    logic [NUM_SRC-1:0] pop_vec;

    logic [RW-1:0]      rr_reg;
    logic [RW-1:0]      rr_next;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign push_vec[gi]  = src_valid[gi] && fifo_ready[gi];
            assign src_ready[gi] = fifo_ready[gi];

            completion_fifo2 #(
                .IW(IW)
            ) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .push     (push_vec[gi]),
                .push_idx (src_idx[gi]),
                .pop      (pop_vec[gi]),
                .squash   (recall_checkpoint),
                .new_front(new_front),
                .al_front (al_front),
                .head     (fifo_head[gi]),
                .count    (fifo_count[gi]),
                .ready    (fifo_ready[gi])
            );
        end
    endgenerate

    // Scan from rr, hand the first NUM_PORTS non-empty buffers to ports in order.
    // No grants during reset or a recall cycle.
    always_comb begin
        int unsigned   np;
        int unsigned   s;
        logic          any;
        logic [RW-1:0] last_src;
        np       = 0;
        s        = 0;
        any      = 1'b0;
        last_src = rr_reg;
        pop_vec  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            completed_valid[p] = 1'b0;
            completed_idx[p]   = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            s = (int'(rr_reg) + k) % NUM_SRC;
            if (!reset && !recall_checkpoint && (fifo_count[s] != 2'd0) && (np < NUM_PORTS)) begin
                pop_vec[s]          = 1'b1;
                completed_valid[np] = 1'b1;
                completed_idx[np]   = fifo_head[s];
                last_src            = RW'(s);
                any                 = 1'b1;
                np                  = np + 1;
            end
        end
        rr_next = any ? RW'((int'(last_src) + 1) % NUM_SRC) : rr_reg;
    end

    // Round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) rr_reg <= '0;
        else       rr_reg <= rr_next;
    end

endmodule

// File: tb/tb_completion_arbiter.sv
// Directed self-checking bench for completion_arbiter (AL_SIZE 32, 4 sources, 2 ports).
module tb_completion_arbiter;

    logic       clk;
    logic       reset;
    logic       src_valid [4];
    logic [4:0] src_idx [4];
    logic       src_ready [4];
    logic       recall_checkpoint;
    logic [4:0] new_front;
    logic [4:0] al_front;
    logic       completed_valid [2];
    logic [4:0] completed_idx [2];

    int checks = 0;
    int errors = 0;

    completion_arbiter #(
        .AL_SIZE  (32),
        .NUM_SRC  (4),
        .NUM_PORTS(2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .src_valid        (src_valid),
        .src_idx          (src_idx),
        .src_ready        (src_ready),
        .recall_checkpoint(recall_checkpoint),
        .new_front        (new_front),
        .al_front         (al_front),
        .completed_valid  (completed_valid),
        .completed_idx    (completed_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_port(input string tag, input int p, input logic ev, input int eidx);
        chk({tag, "_valid"}, 32'(completed_valid[p]), 32'(ev));
        chk({tag, "_idx"}, 32'(completed_idx[p]), ev ? 32'(eidx) : 32'd0);
        $display("port%0d %s: valid=%0d idx=%0d", p, tag, completed_valid[p], completed_idx[p]);
    endtask

    task automatic drive(input int i, input logic v, input int idx);
        src_valid[i] = v;
        src_idx[i]   = 5'(idx);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 0);
    endtask

    task automatic recall(input logic r, input int nf, input int af);
        recall_checkpoint = r;
        new_front         = 5'(nf);
        al_front          = 5'(af);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_all();
        recall(1'b0, 0, 0);
        #1;
        // Reset: nothing valid, nothing ready.
        chk_port("rst_p0", 0, 1'b0, 0);
        chk_port("rst_p1", 1, 1'b0, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_ready%0d", i), 32'(src_ready[i]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("post_rst_ready%0d", i), 32'(src_ready[i]), 32'd1);
        chk_port("post_rst_p0", 0, 1'b0, 0);

        // Single source streaming 3, 4, 5 on src0.
        drive(0, 1'b1, 3); #1;
        chk("stream_ready_a", 32'(src_ready[0]), 32'd1);
        tick();
        drive(0, 1'b1, 4); #1;
        chk_port("stream_3", 0, 1'b1, 3);
        chk_port("stream_p1a", 1, 1'b0, 0);
        chk("stream_ready_b", 32'(src_ready[0]), 32'd1);
        tick();
        drive(0, 1'b1, 5); #1;
        chk_port("stream_4", 0, 1'b1, 4);
        chk_port("stream_p1b", 1, 1'b0, 0);
        chk("stream_ready_c", 32'(src_ready[0]), 32'd1);
        tick();
        idle_all(); #1;
        chk_port("stream_5", 0, 1'b1, 5);
        chk_port("stream_p1c", 1, 1'b0, 0);
        tick();
        chk_port("stream_end", 0, 1'b0, 0);
        // rr is now 1.

        // Round-robin: send 7 on src3 alone to bring rr to 0, then load 10..13.
        drive(3, 1'b1, 7); #1;
        tick();
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 10 + i);
        #1;
        chk_port("rr_setup_7", 0, 1'b1, 7);
        chk_port("rr_setup_p1", 1, 1'b0, 0);
        tick();
        idle_all(); #1;
        chk_port("rr_a_p0", 0, 1'b1, 10);
        chk_port("rr_a_p1", 1, 1'b1, 11);
        tick();
        chk_port("rr_b_p0", 0, 1'b1, 12);
        chk_port("rr_b_p1", 1, 1'b1, 13);
        tick();
        chk_port("rr_c_p0", 0, 1'b0, 0);
        chk_port("rr_c_p1", 1, 1'b0, 0);

        // Backpressure: bring rr to 3 via src2, preload src0/1/3, then starve
        // grants with an empty-window recall while src2 pushes three beats.
        drive(2, 1'b1, 9); #1;
        tick();
        idle_all();
        drive(0, 1'b1, 20); drive(1, 1'b1, 21); drive(3, 1'b1, 23); #1;
        chk_port("bp_setup_9", 0, 1'b1, 9);
        chk_port("bp_setup_p1", 1, 1'b0, 0);
        tick();
        idle_all();
        recall(1'b1, 0, 0);
        drive(2, 1'b1, 26); #1;
        chk_port("bp_beat1", 0, 1'b0, 0);
        chk("bp_ready_beat1", 32'(src_ready[2]), 32'd1);
        tick();
        drive(2, 1'b1, 27); #1;
        chk_port("bp_beat2", 0, 1'b0, 0);
        chk("bp_ready_beat2", 32'(src_ready[2]), 32'd1);
        tick();
        drive(2, 1'b1, 28); #1;
        chk_port("bp_beat3", 0, 1'b0, 0);
        chk("bp_ready_beat3", 32'(src_ready[2]), 32'd0);
        tick();
        idle_all();
        recall(1'b0, 0, 0); #1;
        chk_port("bp_g1_p0", 0, 1'b1, 23);
        chk_port("bp_g1_p1", 1, 1'b1, 20);
        tick();
        chk_port("bp_g2_p0", 0, 1'b1, 21);
        chk_port("bp_g2_p1", 1, 1'b1, 26);
        tick();
        chk_port("bp_g3_p0", 0, 1'b1, 27);
        chk_port("bp_g3_p1", 1, 1'b0, 0);
        tick();
        chk_port("bp_end", 0, 1'b0, 0);
        // rr is 3, all empty.

        // Recall without wrap: src0 = [16,14], src1 = [15,20]; window 16..20.
        recall(1'b1, 0, 0);
        drive(0, 1'b1, 16); drive(1, 1'b1, 15); #1;
        tick();
        drive(0, 1'b1, 14); drive(1, 1'b1, 20); #1;
        tick();
        idle_all();
        recall(1'b1, 15, 20); #1;
        chk_port("rc_cycle_p0", 0, 1'b0, 0);
        chk_port("rc_cycle_p1", 1, 1'b0, 0);
        tick();
        recall(1'b0, 0, 0); #1;
        chk_port("rc_surv_p0", 0, 1'b1, 14);
        chk_port("rc_surv_p1", 1, 1'b1, 15);
        tick();
        chk_port("rc_end", 0, 1'b0, 0);
        // rr is 2.

        // Recall with wrap: src0 = [31,30], src1 = [0,2]; window 31,0,1,2.
        recall(1'b1, 0, 0);
        drive(0, 1'b1, 31); drive(1, 1'b1, 0); #1;
        tick();
        drive(0, 1'b1, 30); drive(1, 1'b1, 2); #1;
        tick();
        idle_all();
        recall(1'b1, 30, 2);
        drive(2, 1'b1, 1); #1;
        chk("rw_in_ready", 32'(src_ready[2]), 32'd1);
        chk_port("rw_cycle_p0", 0, 1'b0, 0);
        tick();
        idle_all();
        recall(1'b0, 0, 0); #1;
        chk_port("rw_surv_p0", 0, 1'b1, 30);
        chk_port("rw_surv_p1", 1, 1'b0, 0);
        tick();
        chk_port("rw_end_p0", 0, 1'b0, 0);

        // Reset mid-stream with five buffered entries.
        recall(1'b1, 0, 0);
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 1 + i);
        #1;
        tick();
        idle_all();
        drive(0, 1'b1, 5); #1;
        tick();
        idle_all();
        recall(1'b0, 0, 0);
        reset = 1'b1; #1;
        chk_port("mid_rst_p0", 0, 1'b0, 0);
        chk("mid_rst_ready0", 32'(src_ready[0]), 32'd0);
        tick();
        reset = 1'b0; #1;
        chk_port("after_rst_p0", 0, 1'b0, 0);
        chk_port("after_rst_p1", 1, 1'b0, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("after_rst_ready%0d", i), 32'(src_ready[i]), 32'd1);
        tick();
        chk_port("stale_p0", 0, 1'b0, 0);
        chk_port("stale_p1", 1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
